// File: rtl/wfq_queue_buf_if.sv
// Queue-side bundle between the descriptor buffer, the enqueue source, the
// weighted-fair scheduler and the downstream consumer.
interface wfq_queue_buf_if #(
  parameter int QUEUE_NUM_WIDTH    = 2,
  parameter int QUEUE_NUM          = 2**QUEUE_NUM_WIDTH,
  parameter int QUEUE_WEIGHT_WIDTH = 7,
  parameter int DATA_WIDTH         = 8
);
  logic                                    enq_vld;
  logic [QUEUE_NUM_WIDTH-1:0]              enq_qid;
  logic [DATA_WIDTH-1:0]                   enq_data;
  logic                                    enq_rdy;
  logic                                    cfg_load;
  logic [QUEUE_NUM*QUEUE_WEIGHT_WIDTH-1:0] cfg_weight;
  logic [QUEUE_NUM*QUEUE_WEIGHT_WIDTH-1:0] wfq_weight;
  logic [QUEUE_NUM-1:0]                    wfq_rdy;
  logic                                    wfq_sch_en;
  logic                                    wfq_winner_vld;
  logic [QUEUE_NUM_WIDTH-1:0]              wfq_winner;
  logic                                    deq_vld;
  logic [QUEUE_NUM_WIDTH-1:0]              deq_qid;
  logic [DATA_WIDTH-1:0]                   deq_data;
  logic                                    deq_rdy;
  logic                                    err_grant;

  modport master (
    output enq_vld, enq_qid, enq_data, cfg_load, cfg_weight,
           wfq_winner_vld, wfq_winner, deq_rdy,
    input  enq_rdy, wfq_weight, wfq_rdy, wfq_sch_en,
           deq_vld, deq_qid, deq_data, err_grant
  );

  modport slave (
    input  enq_vld, enq_qid, enq_data, cfg_load, cfg_weight,
           wfq_winner_vld, wfq_winner, deq_rdy,
    output enq_rdy, wfq_weight, wfq_rdy, wfq_sch_en,
           deq_vld, deq_qid, deq_data, err_grant
  );
endinterface

// File: rtl/wfq_queue_buf.sv
// Per-queue descriptor FIFOs feeding a WFQ scheduler; granted heads pop into
// one registered output stage with a valid/ready handshake.
module wfq_queue_buf #(
  parameter int QUEUE_NUM_WIDTH    = 2,
  parameter int QUEUE_NUM          = 2**QUEUE_NUM_WIDTH,
  parameter int QUEUE_WEIGHT_WIDTH = 7,
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH_WIDTH        = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  wfq_queue_buf_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam int CNT_W = DEPTH_WIDTH + 1;
  localparam int WT_W  = QUEUE_NUM * QUEUE_WEIGHT_WIDTH;

  typedef enum logic [1:0] {ST_EMPTY, ST_SCHED, ST_STALL, ST_DRAIN} state_t;

  logic [DATA_WIDTH-1:0]      mem_q    [QUEUE_NUM][DEPTH];
  logic [DEPTH_WIDTH-1:0]     wr_ptr_q [QUEUE_NUM];
  logic [DEPTH_WIDTH-1:0]     wr_ptr_d [QUEUE_NUM];
  logic [DEPTH_WIDTH-1:0]     rd_ptr_q [QUEUE_NUM];
  logic [DEPTH_WIDTH-1:0]     rd_ptr_d [QUEUE_NUM];
  logic [CNT_W-1:0]           cnt_q    [QUEUE_NUM];
  logic [CNT_W-1:0]           cnt_d    [QUEUE_NUM];
  logic [QUEUE_NUM-1:0]       rdy, full, enq_hit, pop_hit;
  logic [WT_W-1:0]            weight_q, weight_d;
  logic                       err_q, err_d;
  logic                       vld_p1, vld_p1_d;
  logic [QUEUE_NUM_WIDTH-1:0] qid_p1, qid_p1_d;
  logic [DATA_WIDTH-1:0]      data_p1, data_p1_d;
  state_t                     state_q, state_d;
  logic                       out_free, sch_en, enq_ok, grant_ok, grant_bad, any_d;

  always_comb begin
    for (int i = 0; i < QUEUE_NUM; i++) begin
      rdy[i]  = (cnt_q[i] != '0);
      full[i] = (cnt_q[i] == CNT_W'(DEPTH));
    end
  end

  assign out_free  = !vld_p1 || bus.deq_rdy;
  assign sch_en    = (|rdy) && out_free;
  assign enq_ok    = bus.enq_vld && !full[bus.enq_qid];
  assign grant_ok  = bus.wfq_winner_vld && sch_en && rdy[bus.wfq_winner];
  assign grant_bad = bus.wfq_winner_vld && sch_en && !rdy[bus.wfq_winner];

  always_comb begin
    weight_d = bus.cfg_load ? bus.cfg_weight : weight_q;
    err_d    = err_q || grant_bad;
    enq_hit  = '0;
    pop_hit  = '0;
    any_d    = 1'b0;
    for (int i = 0; i < QUEUE_NUM; i++) begin
      enq_hit[i]  = enq_ok && (bus.enq_qid == QUEUE_NUM_WIDTH'(i));
      pop_hit[i]  = grant_ok && (bus.wfq_winner == QUEUE_NUM_WIDTH'(i));
      wr_ptr_d[i] = enq_hit[i] ? wr_ptr_q[i] + DEPTH_WIDTH'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop_hit[i] ? rd_ptr_q[i] + DEPTH_WIDTH'(1) : rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i] + CNT_W'(enq_hit[i]) - CNT_W'(pop_hit[i]);
      any_d       = any_d || (cnt_d[i] != '0);
    end
  end

  // Output stage p1: reloads on an accepted grant, otherwise drains on deq_rdy.
  always_comb begin
    vld_p1_d  = vld_p1;
    qid_p1_d  = qid_p1;
    data_p1_d = data_p1;
    if (grant_ok) begin
      vld_p1_d  = 1'b1;
      qid_p1_d  = bus.wfq_winner;
      data_p1_d = mem_q[bus.wfq_winner][rd_ptr_q[bus.wfq_winner]];
    end else if (bus.deq_rdy) begin
      vld_p1_d  = 1'b0;
    end
  end

  always_comb begin
    state_d = ST_SCHED;
    if (!any_d && !vld_p1_d)            state_d = ST_EMPTY;
    else if (vld_p1_d && !any_d)        state_d = ST_DRAIN;
    else if (vld_p1_d && !bus.deq_rdy)  state_d = ST_STALL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_NUM; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        weight_q[i*QUEUE_WEIGHT_WIDTH +: QUEUE_WEIGHT_WIDTH] <= QUEUE_WEIGHT_WIDTH'(1);
      end
      err_q   <= 1'b0;
      vld_p1  <= 1'b0;
      qid_p1  <= '0;
      data_p1 <= '0;
      state_q <= ST_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      weight_q <= weight_d;
      err_q    <= err_d;
      vld_p1   <= vld_p1_d;
      qid_p1   <= qid_p1_d;
      data_p1  <= data_p1_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok) mem_q[bus.enq_qid][wr_ptr_q[bus.enq_qid]] <= bus.enq_data;
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_EMPTY) |-> (!vld_p1 && (rdy == '0)));

  assign bus.enq_rdy    = !full[bus.enq_qid];
  assign bus.wfq_weight = weight_q;
  assign bus.wfq_rdy    = rdy;
  assign bus.wfq_sch_en = sch_en;
  assign bus.deq_vld    = vld_p1;
  assign bus.deq_qid    = qid_p1;
  assign bus.deq_data   = data_p1;
  assign bus.err_grant  = err_q;
endmodule

// File: tb/tb_wfq_queue_buf.sv
// Directed bench for wfq_queue_buf: enqueue, grant, backpressure, error flag,
// pointer wrap, weight load and mid-stream reset.
module tb_wfq_queue_buf;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  localparam logic [27:0] W_RST = {7'd1, 7'd1, 7'd1, 7'd1};
  localparam logic [27:0] W_CFG = {7'd5, 7'd9, 7'd2, 7'd100};

  wfq_queue_buf_if #(.QUEUE_NUM_WIDTH(2), .QUEUE_NUM(4), .QUEUE_WEIGHT_WIDTH(7),
                     .DATA_WIDTH(8)) bus ();

  wfq_queue_buf #(.QUEUE_NUM_WIDTH(2), .QUEUE_NUM(4), .QUEUE_WEIGHT_WIDTH(7),
                  .DATA_WIDTH(8), .DEPTH_WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.enq_vld        = 1'b0;
    bus.enq_qid        = '0;
    bus.enq_data       = '0;
    bus.cfg_load       = 1'b0;
    bus.cfg_weight     = '0;
    bus.wfq_winner_vld = 1'b0;
    bus.wfq_winner     = '0;
    bus.deq_rdy        = 1'b1;
  endtask

  task automatic enq(input int q, input int d);
    bus.enq_vld  = 1'b1;
    bus.enq_qid  = 2'(q);
    bus.enq_data = 8'(d);
    tick();
    bus.enq_vld  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_rdy"},    32'(bus.wfq_rdy),    32'h0);
    check_eq({tag, "_schen"},  32'(bus.wfq_sch_en), 32'h0);
    check_eq({tag, "_vld"},    32'(bus.deq_vld),    32'h0);
    check_eq({tag, "_qid"},    32'(bus.deq_qid),    32'h0);
    check_eq({tag, "_data"},   32'(bus.deq_data),   32'h0);
    check_eq({tag, "_err"},    32'(bus.err_grant),  32'h0);
    check_eq({tag, "_weight"}, 32'(bus.wfq_weight), 32'(W_RST));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    check_reset_state("rst");
    rst_n = 1'b1;

    // single descriptor through q2
    bus.enq_vld = 1'b1; bus.enq_qid = 2'd2; bus.enq_data = 8'hA1;
    #1;
    check_eq("t1_enq_rdy", 32'(bus.enq_rdy), 32'h1);
    tick();
    bus.enq_vld = 1'b0;
    check_eq("t1_wfq_rdy", 32'(bus.wfq_rdy), 32'h4);
    check_eq("t1_schen", 32'(bus.wfq_sch_en), 32'h1);
    bus.wfq_winner_vld = 1'b1; bus.wfq_winner = 2'd2;
    tick();
    bus.wfq_winner_vld = 1'b0;
    check_eq("t1_deq_vld", 32'(bus.deq_vld), 32'h1);
    check_eq("t1_deq_qid", 32'(bus.deq_qid), 32'h2);
    check_eq("t1_deq_data", 32'(bus.deq_data), 32'hA1);
    check_eq("t1_rdy_clr", 32'(bus.wfq_rdy), 32'h0);
    tick();
    check_eq("t1_vld_clr", 32'(bus.deq_vld), 32'h0);

    // fill q0, refused fifth write with same-cycle pop
    for (int i = 0; i < 4; i++) enq(0, 'h10 + i);
    bus.enq_qid = 2'd0; #1;
    check_eq("t2_full_q0", 32'(bus.enq_rdy), 32'h0);
    bus.enq_qid = 2'd1; #1;
    check_eq("t2_free_q1", 32'(bus.enq_rdy), 32'h1);
    bus.enq_vld = 1'b1; bus.enq_qid = 2'd0; bus.enq_data = 8'h55;
    bus.wfq_winner_vld = 1'b1; bus.wfq_winner = 2'd0;
    tick();
    bus.enq_vld = 1'b0;
    check_eq("t2_pop0", 32'(bus.deq_data), 32'h10);
    check_eq("t2_rdy_after", 32'(bus.enq_rdy), 32'h1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_eq("t2_pop", 32'(bus.deq_data), 32'(8'h10 + i));
    end
    check_eq("t2_empty", 32'(bus.wfq_rdy), 32'h0);
    bus.wfq_winner_vld = 1'b0;
    tick();

    // backpressure then back-to-back reload
    enq(1, 'hB0);
    enq(1, 'hB1);
    enq(0, 'hC0);
    bus.wfq_winner_vld = 1'b1; bus.wfq_winner = 2'd1;
    tick();
    check_eq("t3_first", 32'(bus.deq_data), 32'hB0);
    bus.deq_rdy = 1'b0; bus.wfq_winner = 2'd0; #1;
    check_eq("t3_schen_lo", 32'(bus.wfq_sch_en), 32'h0);
    tick();
    check_eq("t3_hold_data", 32'(bus.deq_data), 32'hB0);
    check_eq("t3_hold_vld", 32'(bus.deq_vld), 32'h1);
    check_eq("t3_hold_rdy", 32'(bus.wfq_rdy), 32'h3);
    check_eq("t3_no_err", 32'(bus.err_grant), 32'h0);
    bus.deq_rdy = 1'b1; bus.wfq_winner = 2'd1; #1;
    check_eq("t3_schen_hi", 32'(bus.wfq_sch_en), 32'h1);
    tick();
    bus.wfq_winner_vld = 1'b0;
    check_eq("t3_b2b_vld", 32'(bus.deq_vld), 32'h1);
    check_eq("t3_b2b_qid", 32'(bus.deq_qid), 32'h1);
    check_eq("t3_b2b_data", 32'(bus.deq_data), 32'hB1);
    check_eq("t3_rdy", 32'(bus.wfq_rdy), 32'h1);
    tick();
    check_eq("t3_drain", 32'(bus.deq_vld), 32'h0);

    // grant to empty q3 while q0 holds C0
    bus.wfq_winner_vld = 1'b1; bus.wfq_winner = 2'd3;
    tick();
    bus.wfq_winner_vld = 1'b0;
    check_eq("t4_err", 32'(bus.err_grant), 32'h1);
    check_eq("t4_no_pop", 32'(bus.deq_vld), 32'h0);
    check_eq("t4_rdy", 32'(bus.wfq_rdy), 32'h1);
    tick();
    check_eq("t4_sticky", 32'(bus.err_grant), 32'h1);
    bus.wfq_winner_vld = 1'b1; bus.wfq_winner = 2'd0;
    tick();
    bus.wfq_winner_vld = 1'b0;
    check_eq("t4_c0", 32'(bus.deq_data), 32'hC0);
    tick();

    // 16 descriptors, round-robin grants, pointer wrap on q0/q1/q2
    for (int q = 0; q < 4; q++)
      for (int i = 0; i < 4; i++) enq(q, 'h40 + q*16 + i);
    check_eq("t5_all_rdy", 32'(bus.wfq_rdy), 32'hF);
    for (int k = 0; k < 16; k++) begin
      bus.wfq_winner_vld = 1'b1; bus.wfq_winner = 2'(k % 4);
      tick();
      check_eq("t5_qid", 32'(bus.deq_qid), 32'(k % 4));
      check_eq("t5_data", 32'(bus.deq_data), 32'('h40 + (k % 4)*16 + k/4));
    end
    bus.wfq_winner_vld = 1'b0;
    tick();
    check_eq("t5_empty", 32'(bus.wfq_rdy), 32'h0);
    check_eq("t5_vld", 32'(bus.deq_vld), 32'h0);
    check_eq("t5_err_kept", 32'(bus.err_grant), 32'h1);

    // weight load and hold
    bus.cfg_weight = W_CFG; bus.cfg_load = 1'b1; #1;
    check_eq("t6_w_before", 32'(bus.wfq_weight), 32'(W_RST));
    tick();
    bus.cfg_load = 1'b0; bus.cfg_weight = '0;
    check_eq("t6_w_load", 32'(bus.wfq_weight), 32'(W_CFG));
    tick();
    check_eq("t6_w_hold", 32'(bus.wfq_weight), 32'(W_CFG));

    // mid-stream reset with a pending grant
    enq(1, 'hD0);
    bus.wfq_winner_vld = 1'b1; bus.wfq_winner = 2'd1;
    bus.enq_vld = 1'b1; bus.enq_qid = 2'd2; bus.enq_data = 8'hD1;
    tick();
    bus.enq_vld = 1'b0;
    check_eq("t7_pre_data", 32'(bus.deq_data), 32'hD0);
    check_eq("t7_pre_rdy", 32'(bus.wfq_rdy), 32'h4);
    bus.deq_rdy = 1'b0; bus.wfq_winner = 2'd2;
    rst_n = 1'b0;
    tick();
    check_reset_state("t7_rst");
    rst_n = 1'b1;
    idle();
    tick();
    check_eq("t7_post_vld", 32'(bus.deq_vld), 32'h0);
    check_eq("t7_post_rdy", 32'(bus.wfq_rdy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
